dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared data memory. Accepts load/store requests from the pipeline MEM stage (port 0) and from the loader/DMA port (port 1). It grants one request at a time and drives the dmem control, address and write-data pins from a registered command. It returns the read data and a completion pulse to the winning requester. It sits between the `mem_stage` requesters and `dmem`, replacing the direct wiring of `memread`/`memwrite`/`addr`/`wd`.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the two-port dmem arbiter
package dmem_arb_pkg;
  localparam int NUM_PORTS = 2;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo & ALIGN_MASK) != 2'b00;
  endfunction
endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - one-hot grant picker; fixed priority (port 0) by default,
// round-robin tie-break when DMEM_ARB_RR_EN is defined
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
`ifdef DMEM_ARB_RR_EN
  input  port_id_t             last_grant,
`endif
  output logic [NUM_PORTS-1:0] grant
);
  logic prefer_p1;

  always_comb begin
`ifdef DMEM_ARB_RR_EN
    prefer_p1 = (last_grant == 1'b0);
`else
    prefer_p1 = 1'b0;
`endif
    grant[0] = valid[0] & (~valid[1] | ~prefer_p1);
    grant[1] = valid[1] & (~valid[0] |  prefer_p1);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port load/store arbiter and sequencer for the shared dmem
// (IDLE -> ISSUE -> RESP); DMEM_ARB_RR_EN selects round-robin arbitration
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS-1:0]              req_we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_wd,
  output logic [NUM_PORTS-1:0]              req_ready,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [DATA_W-1:0]                 rsp_rd,
  output logic                              rsp_err,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wd,
  input  logic [DATA_W-1:0]                 mem_rd,
  output logic                              busy
);
  arb_state_t           state_q, state_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wd_q, wd_d;
  port_id_t             id_q, id_d;
  logic [DATA_W-1:0]    rsp_rd_q, rsp_rd_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [NUM_PORTS-1:0] grant;
  port_id_t             grant_id;
  logic                 in_idle, in_issue, in_resp, misaligned;

`ifdef DMEM_ARB_RR_EN
  port_id_t last_q, last_d;

  dmem_arb_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );
`else
  dmem_arb_pick u_pick (
    .valid (req_valid),
    .grant (grant)
  );
`endif

  assign in_idle    = (state_q == IDLE);
  assign in_issue   = (state_q == ISSUE);
  assign in_resp    = (state_q == RESP);
  assign misaligned = is_misaligned(addr_q[1:0]);
  assign grant_id   = grant[1];

  assign req_ready = (in_idle && !reset) ? grant : '0;
  assign busy      = !in_idle;

  // Strobes gated by ~reset so an ISSUE cycle cut short by reset never writes.
  assign mem_read  = in_issue & ~we_q & ~misaligned & ~reset;
  assign mem_write = in_issue &  we_q & ~misaligned & ~reset;
  assign mem_addr  = in_issue ? addr_q : '0;
  assign mem_wd    = in_issue ? wd_q : '0;

  assign rsp_valid = in_resp ? {id_q, ~id_q} : '0;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    id_d      = id_q;
    rsp_rd_d  = rsp_rd_q;
    rsp_err_d = rsp_err_q;
`ifdef DMEM_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          we_d    = req_we[grant_id];
          addr_d  = req_addr[grant_id];
          wd_d    = req_wd[grant_id];
          id_d    = grant_id;
          state_d = ISSUE;
`ifdef DMEM_ARB_RR_EN
          last_d  = grant_id;
`endif
        end
      end
      ISSUE: begin
        rsp_err_d = misaligned;
        rsp_rd_d  = misaligned ? '0 : mem_rd;
        state_d   = RESP;
      end
      RESP: begin
        rsp_err_d = 1'b0;
        rsp_rd_d  = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      id_q      <= 1'b0;
      rsp_rd_q  <= '0;
      rsp_err_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      id_q      <= id_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_err_q <= rsp_err_d;
`ifdef DMEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (directed + randomized
// against a transaction-level model; honours DMEM_ARB_RR_EN)
`timescale 1ns/1ps
module tb_dmem_arbiter;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_we, req_ready, rsp_valid;
  logic [1:0][31:0] req_addr, req_wd;
  logic [31:0]      rsp_rd, mem_addr, mem_wd, mem_rd;
  logic             rsp_err, mem_read, mem_write, busy;
  logic             mem_clear;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] env_mem [16];
  logic [31:0] ref_mem [16];
  logic        ref_last;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wd(req_wd),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 | (i * 32'h111);
  endfunction

  // Behavioural dmem: combinational read, write on the rising edge.
  assign mem_rd = env_mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
    end else if (mem_write) begin
      env_mem[mem_addr[5:2]] <= mem_wd;
    end
  end

  function automatic logic [1:0] ref_pick(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      return ref_last ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return v;
  endfunction

  task automatic model_accept(input int p, input logic we, input logic [31:0] a,
                              input logic [31:0] wd);
    if (we && a[1:0] == 2'b00) ref_mem[a[5:2]] = wd;
    ref_last = p[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from IDLE; returns what the DUT showed at N, N+1, N+2.
  task automatic run_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output logic [1:0] rdy0, output logic rd1, output logic wr1,
                         output logic [31:0] a1, output logic [31:0] wd1,
                         output logic [1:0] rv2, output logic [31:0] rd2,
                         output logic err2, output logic strb2);
    req_valid = 2'b00;
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_addr[p] = a;
    req_wd[p] = wd;
    #1 rdy0 = req_ready;
    step();
    req_valid = 2'b00;
    rd1 = mem_read; wr1 = mem_write; a1 = mem_addr; wd1 = mem_wd;
    step();
    rv2 = rsp_valid; rd2 = rsp_rd; err2 = rsp_err; strb2 = mem_read | mem_write;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clear = 1'b1;
    req_valid = 2'b11; req_we = 2'b11;
    req_addr = {32'h4, 32'h8}; req_wd = {32'h1, 32'h2};
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    ref_last = 1'b1;
    step(); step();
    n_checks++;
    if ({req_ready, rsp_valid, mem_read, mem_write, busy, rsp_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 00000000",
               {req_ready, rsp_valid, mem_read, mem_write, busy, rsp_err});
    end
    n_checks++;
    if ({mem_addr, mem_wd, rsp_rd} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h, want 0", mem_addr, mem_wd, rsp_rd);
    end
    req_valid = 2'b00; mem_clear = 1'b0; reset = 1'b0;
    step();
  endtask

  task automatic test_store_load();
    logic [1:0] r0, rv2; logic rd1, wr1, err2, s2; logic [31:0] a1, wd1, rd2;
    run_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, r0, rd1, wr1, a1, wd1, rv2, rd2, err2, s2);
    model_accept(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    n_checks++;
    if (r0 !== 2'b01) begin n_fail++; $display("FAIL st_ready: got %b, want 01", r0); end
    n_checks++;
    if ({rd1, wr1} !== 2'b01) begin n_fail++; $display("FAIL st_strobe: got rd/wr %b, want 01", {rd1, wr1}); end
    n_checks++;
    if (a1 !== 32'h10 || wd1 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL st_bus: got %h/%h, want 00000010/deadbeef", a1, wd1);
    end
    n_checks++;
    if (rv2 !== 2'b01 || s2 !== 1'b0) begin
      n_fail++; $display("FAIL st_rsp: got rsp_valid %b strobe %b, want 01 0", rv2, s2);
    end
    run_txn(0, 1'b0, 32'h10, 32'h0, r0, rd1, wr1, a1, wd1, rv2, rd2, err2, s2);
    model_accept(0, 1'b0, 32'h10, 32'h0);
    n_checks++;
    if ({rd1, wr1} !== 2'b10) begin n_fail++; $display("FAIL ld_strobe: got rd/wr %b, want 10", {rd1, wr1}); end
    n_checks++;
    if (rv2 !== 2'b01 || rd2 !== 32'hDEAD_BEEF || err2 !== 1'b0) begin
      n_fail++; $display("FAIL ld_rsp: got %b %h %b, want 01 deadbeef 0", rv2, rd2, err2);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0] r0, rv2; logic rd1, wr1, err2, s2; logic [31:0] a1, wd1, rd2;
    run_txn(1, 1'b0, 32'h6, 32'h0, r0, rd1, wr1, a1, wd1, rv2, rd2, err2, s2);
    model_accept(1, 1'b0, 32'h6, 32'h0);
    n_checks++;
    if (r0 !== 2'b10) begin n_fail++; $display("FAIL mis_ready: got %b, want 10", r0); end
    n_checks++;
    if ({rd1, wr1} !== 2'b00) begin n_fail++; $display("FAIL mis_strobe: got %b, want 00", {rd1, wr1}); end
    n_checks++;
    if (rv2 !== 2'b10 || err2 !== 1'b1 || rd2 !== 32'h0) begin
      n_fail++; $display("FAIL mis_rsp: got %b %b %h, want 10 1 00000000", rv2, err2, rd2);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp; int w;
    // Ties where the loser withdraws: winners must follow the arbitration rule.
    for (int r = 0; r < 4; r++) begin
      req_valid = 2'b11; req_we = 2'b00;
      req_addr = {32'h24, 32'h28}; req_wd = '0;
      #1 exp = ref_pick(2'b11);
      n_checks++;
      if (req_ready !== exp) begin n_fail++; $display("FAIL tie_%0d: got %b, want %b", r, req_ready, exp); end
      w = exp[1] ? 1 : 0;
      model_accept(w, 1'b0, req_addr[w], 32'h0);
      step();
      req_valid = 2'b00;
      step();
      n_checks++;
      if (rsp_valid !== exp) begin n_fail++; $display("FAIL tie_rsp_%0d: got %b, want %b", r, rsp_valid, exp); end
      step();
    end
    // Tie where the loser keeps waiting: it is served three cycles later.
    req_valid = 2'b11;
    #1 exp = ref_pick(2'b11);
    w = exp[1] ? 1 : 0;
    model_accept(w, 1'b0, req_addr[w], 32'h0);
    step();
    req_valid[w] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin n_fail++; $display("FAIL tie_wait_%0d: got %b, want 00", c, req_ready); end
      @(posedge clk); #1;
    end
    #1;
    n_checks++;
    if (req_ready !== ~exp) begin n_fail++; $display("FAIL tie_loser: got %b, want %b", req_ready, ~exp); end
    model_accept(1 - w, 1'b0, req_addr[1 - w], 32'h0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic [6:0] rdy, bsy;
    req_valid = 2'b01; req_we[0] = 1'b0; req_addr[0] = 32'h4; req_wd[0] = '0;
    for (int i = 0; i < 7; i++) begin
      #1;
      rdy[i] = req_ready[0];
      bsy[i] = busy;
      if (req_ready[0]) model_accept(0, 1'b0, 32'h4, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    step(); step();
    n_checks++;
    if (rdy !== 7'b1001001) begin n_fail++; $display("FAIL b2b_ready: got %b, want 1001001", rdy); end
    n_checks++;
    if (bsy !== 7'b0110110) begin n_fail++; $display("FAIL b2b_busy: got %b, want 0110110", bsy); end
  endtask

  task automatic test_reset_mid_issue();
    logic [1:0] r0, rv2; logic rd1, wr1, err2, s2; logic [31:0] a1, wd1, rd2, prior;
    prior = ref_mem[8];
    req_valid = 2'b01; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wd[0] = 32'h1234_5678;
    step();
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_issue_wr: got %b, want 0", mem_write); end
    @(posedge clk); #1;
    reset = 1'b0;
    ref_last = 1'b1;
    n_checks++;
    if ({rsp_valid, mem_read, mem_write, busy, rsp_err, mem_addr, mem_wd, rsp_rd} !== '0) begin
      n_fail++;
      $display("FAIL rst_after: got %b %b %b %b %b %h %h %h, want all 0",
               rsp_valid, mem_read, mem_write, busy, rsp_err, mem_addr, mem_wd, rsp_rd);
    end
    step();
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_norsp: got %b, want 00", rsp_valid); end
    run_txn(0, 1'b0, 32'h20, 32'h0, r0, rd1, wr1, a1, wd1, rv2, rd2, err2, s2);
    model_accept(0, 1'b0, 32'h20, 32'h0);
    n_checks++;
    if (rv2 !== 2'b01 || rd2 !== prior) begin
      n_fail++; $display("FAIL rst_reload: got %b %h, want 01 %h", rv2, rd2, prior);
    end
  endtask

  task automatic test_random();
    int ph = 0;
    int c_port = 0;
    logic c_we, c_al;
    logic [31:0] c_addr, c_wd, c_rd;
    logic [1:0] exp;
    req_valid = 2'b00;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (ph == 1) begin
        n_checks++;
        if ({mem_read, mem_write, busy, rsp_valid} !== {!c_we && c_al, c_we && c_al, 1'b1, 2'b00}) begin
          n_fail++; $display("FAIL rnd_issue_ctl @%0d: got %b, want %b", cyc,
            {mem_read, mem_write, busy, rsp_valid}, {!c_we && c_al, c_we && c_al, 1'b1, 2'b00});
        end
        n_checks++;
        if (mem_addr !== c_addr || mem_wd !== c_wd) begin
          n_fail++; $display("FAIL rnd_issue_bus @%0d: got %h/%h, want %h/%h", cyc, mem_addr, mem_wd, c_addr, c_wd);
        end
      end else if (ph == 2) begin
        n_checks++;
        if (rsp_valid !== (2'b01 << c_port) || rsp_err !== !c_al || (mem_read | mem_write) !== 1'b0) begin
          n_fail++; $display("FAIL rnd_rsp @%0d: got %b %b %b, want %b %b 0", cyc, rsp_valid, rsp_err,
            mem_read | mem_write, 2'b01 << c_port, !c_al);
        end
        if (!c_we || !c_al) begin
          n_checks++;
          if (rsp_rd !== c_rd) begin n_fail++; $display("FAIL rnd_rd @%0d: got %h, want %h", cyc, rsp_rd, c_rd); end
        end
      end else begin
        n_checks++;
        if ({busy, rsp_valid, mem_read, mem_write} !== 5'b0) begin
          n_fail++; $display("FAIL rnd_idle @%0d: got %b, want 00000", cyc, {busy, rsp_valid, mem_read, mem_write});
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p]) begin
          if ($urandom_range(0, 9) == 0) req_valid[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[p] = 1'b1;
          req_we[p] = 1'($urandom_range(0, 1));
          req_addr[p] = {26'd0, 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
          req_wd[p] = $urandom;
        end
      end
      #1;
      exp = (ph == 0) ? ref_pick(req_valid) : 2'b00;
      n_checks++;
      if (req_ready !== exp) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b, want %b", cyc, req_ready, exp); end
      if (ph == 1) ph = 2;
      else if (ph == 2) ph = 0;
      else if (exp != 2'b00) begin
        c_port = exp[1] ? 1 : 0;
        c_we = req_we[c_port];
        c_addr = req_addr[c_port];
        c_wd = req_wd[c_port];
        c_al = (c_addr[1:0] == 2'b00);
        c_rd = c_al ? ref_mem[c_addr[5:2]] : 32'h0;
        model_accept(c_port, c_we, c_addr, c_wd);
        ph = 1;
      end
      @(posedge clk); #1;
      if (ph == 1) req_valid[c_port] = 1'b0;
    end
    req_valid = 2'b00;
    step(); step(); step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mem_clear = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wd = '0;
    @(posedge clk); #1;
    test_reset();
    test_store_load();
    test_misaligned();
    test_tie();
    test_back_to_back();
    test_reset_mid_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
